aes_inv_round_ctrl: RTL and testbench
=====================================

// Module: aes_inv_round_ctrl
// PURPOSE
// - Decrypt-side state register and round sequencer for the iterative AES-128 core; the inverse-direction counterpart of the encrypt AddRoundKey stage.
// - Loads ciphertext, applies round keys in descending order 10..0, applies InvMixColumns internally on rounds 9..1, and returns plaintext over a valid/ready handshake.
// - InvShiftRows+InvSubBytes is external combinational logic: fed from sa_o, returned on inv_sb_in.
// PARAMETERS
// - NR  10  number of rounds; sets the start key index and the round-counter range (AES-128 only)
// PORTS
// - clk        in   1    core clock, rising edge
// - rst_n      in   1    asynchronous active-low reset
// - ld         in   1    start pulse; sampled only in IDLE
// - text_in    in   128  ciphertext; [127:120]=sa00, column-major, same byte map as encrypt side
// - kreq       out  1    round-key request, high in KEY and ROUND states
// - kround     out  4    index of requested round key (NR..0)
// - kvalid     in   1    w_0..w_3 hold key kround this cycle
// - w_0..w_3   in   32   round-key words; w_0 = column 0, [31:24] = row 0
// - sa_o       out  128  current state, drives external InvShiftRows/InvSubBytes
// - inv_sb_in  in   128  InvSubBytes(InvShiftRows(sa_o)), combinational return
// - busy       out  1    high from load acceptance until output handshake
// - out_valid  out  1    plaintext valid on text_out
// - out_ready  in   1    consumer accepts text_out
// - text_out   out  128  plaintext, equal to sa_o while out_valid
// BEHAVIOUR
// - Reset: state IDLE; sa_o, text_r, text_out = 0; kround = 0; kreq, busy, out_valid = 0.
// - FSM: IDLE -> KEY -> ROUND -> DONE -> IDLE.
// - IDLE: when ld=1, text_r<=text_in, round<=NR, busy<=1, go KEY.
// - KEY: kreq=1, kround=NR. When kvalid=1: sa<=text_r^{w_0,w_1,w_2,w_3}, round<=NR-1, go ROUND.
// - KEY/ROUND with kvalid=0: hold every register; kreq stays high (stall, no timeout).
// - ROUND: kreq=1, kround=round. When kvalid=1: t=inv_sb_in^{w_0..w_3}.
// - ROUND, round!=0: sa<=InvMixColumns(t), round<=round-1.
// - ROUND, round==0: sa<=t, go DONE. No InvMixColumns in the final round.
// - InvMixColumns: per column, GF(2^8) multiply by {0e,0b,0d,09} matrix, poly 0x11b, implemented via xtime chains.
// - DONE: out_valid=1, text_out=sa. out_ready=1 -> out_valid<=0, busy<=0, go IDLE.
// - DONE output hold: out_valid and text_out held stable until accepted; out_ready while out_valid=0 is ignored.
// - Latency with kvalid tied high: ld at cycle T -> out_valid rises at T+12.
// - ld while busy: ignored, no queuing; same-cycle ld with DONE acceptance is ignored (IDLE reached next cycle).
// - Round counter: 4 bits, counts NR-1 down to 0, never wraps.
// - kround: 0 outside KEY/ROUND.
// - rst_n low mid-operation: immediate return to reset values, in-flight block discarded.
// CONFIGURATION
// - AES_INV_ZEROIZE_EN defined: on the DONE->IDLE transition, sa, text_r and text_out clear to 0. No plaintext or ciphertext residue remains in IDLE.
// - AES_INV_ZEROIZE_EN undefined: registers keep their last values in IDLE.
// - Cycle timing identical in both builds.
// TESTING
// - FIPS-197 C.1: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, key schedule of 000102..0f, kvalid=1 -> text_out=00112233445566778899aabbccddeeff, out_valid at T+12.
// - Key stall: same vector, kvalid low 3 cycles in KEY and 2 cycles at round 5 -> same plaintext at T+17; sa_o frozen during stalls; kround=10 then 9..0 in order.
// - Backpressure: out_ready low 4 cycles in DONE -> out_valid and text_out stable; ld pulses during busy ignored; next ld after acceptance decrypts correctly.
// - Reset mid-op: rst_n low at round 4 -> all outputs 0 asynchronously; a new ld after release yields the correct plaintext.
// - Back-to-back: two ciphertexts with out_ready=1 and ld asserted the cycle after acceptance -> both plaintexts correct, no state carry-over.
// - AES_INV_ZEROIZE_EN defined: after acceptance, text_out=0 and sa_o=0 next cycle; undefined: text_out retains plaintext.

Source files
------------

// File: rtl/aes_inv_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_inv_round_ctrl
// Decrypt-side state register and round sequencer for the iterative AES-128
// core. Loads a ciphertext, applies round keys NR..0, runs InvMixColumns on
// the middle rounds and presents the plaintext over a valid/ready handshake.
// InvShiftRows + InvSubBytes are external: fed from sa_o, returned on
// inv_sb_in in the same cycle.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   ld, text_in         start pulse (IDLE only) and 128-bit ciphertext
//   kreq, kround        round-key request and index (NR..0, 0 when idle)
//   kvalid, w_0..w_3    key words for kround are present this cycle
//   sa_o, inv_sb_in     state out / InvSubBytes(InvShiftRows(sa_o)) back
//   busy                load accepted, result not yet handed over
//   out_valid,
//   out_ready, text_out plaintext handshake
//
// Build option
//   AES_INV_ZEROIZE_EN  clear sa, text_r and text_out on DONE->IDLE so no
//                       plaintext or ciphertext residue stays in IDLE.
// ---------------------------------------------------------------------------
module aes_inv_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [127:0] text_in,
  output logic         kreq,
  output logic [3:0]   kround,
  input  logic         kvalid,
  input  logic [31:0]  w_0,
  input  logic [31:0]  w_1,
  input  logic [31:0]  w_2,
  input  logic [31:0]  w_3,
  output logic [127:0] sa_o,
  input  logic [127:0] inv_sb_in,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] text_out
);

  typedef enum logic [1:0] {S_IDLE, S_KEY, S_ROUND, S_DONE} state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  state_t       state, state_nxt;
  logic [127:0] sa, text_r, text_out_r;
  logic [3:0]   round;
  logic [127:0] rk, t, imc_t;

  // ---- GF(2^8) helpers, poly 0x11b --------------------------------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Returns {0e*b, 0b*b, 0d*b, 09*b} built from one xtime chain.
  function automatic logic [31:0] mul_set(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x2 ^ b, x8 ^ x4 ^ b, x8 ^ b};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [31:0] m0, m1, m2, m3;   // fields: [31:24]=0e [23:16]=0b [15:8]=0d [7:0]=09
    m0 = mul_set(c[31:24]);
    m1 = mul_set(c[23:16]);
    m2 = mul_set(c[15:8]);
    m3 = mul_set(c[7:0]);
    return {m0[31:24] ^ m1[23:16] ^ m2[15:8]  ^ m3[7:0],
            m0[7:0]   ^ m1[31:24] ^ m2[23:16] ^ m3[15:8],
            m0[15:8]  ^ m1[7:0]   ^ m2[31:24] ^ m3[23:16],
            m0[23:16] ^ m1[15:8]  ^ m2[7:0]   ^ m3[31:24]};
  endfunction

  // ---- round datapath ---------------------------------------------------
  assign rk = {w_0, w_1, w_2, w_3};
  assign t  = inv_sb_in ^ rk;

  for (genvar col = 0; col < 4; col++) begin : g_imc
    assign imc_t[127-32*col -: 32] = inv_mix_col(t[127-32*col -: 32]);
  end

  // ---- FSM: state register ----------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---- FSM: next state --------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ld)                         state_nxt = S_KEY;
      S_KEY:   if (kvalid)                     state_nxt = S_ROUND;
      S_ROUND: if (kvalid && round == 4'd0)    state_nxt = S_DONE;
      S_DONE:  if (out_ready)                  state_nxt = S_IDLE;
      default:                                 state_nxt = S_IDLE;
    endcase
  end

  // ---- FSM: outputs -----------------------------------------------------
  always_comb begin
    kreq      = 1'b0;
    kround    = 4'd0;
    busy      = (state != S_IDLE);
    out_valid = (state == S_DONE);
    case (state)
      S_KEY:   begin kreq = 1'b1; kround = NR_L;  end
      S_ROUND: begin kreq = 1'b1; kround = round; end
      default: ;
    endcase
  end

  // ---- state / text registers; every path holds while kvalid is low -----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa         <= '0;
      text_r     <= '0;
      text_out_r <= '0;
      round      <= '0;
    end else begin
      case (state)
        S_IDLE: if (ld) begin
          text_r <= text_in;
          round  <= NR_L;
        end
        S_KEY: if (kvalid) begin
          sa    <= text_r ^ rk;
          round <= NR_L - 4'd1;
        end
        S_ROUND: if (kvalid) begin
          if (round != 4'd0) begin
            sa    <= imc_t;
            round <= round - 4'd1;
          end else begin
            // final round skips InvMixColumns
            sa         <= t;
            text_out_r <= t;
          end
        end
        S_DONE: if (out_ready) begin
`ifdef AES_INV_ZEROIZE_EN
          sa         <= '0;
          text_r     <= '0;
          text_out_r <= '0;
`else
          text_out_r <= text_out_r;
`endif
        end
        default: ;
      endcase
    end
  end

  assign sa_o     = sa;
  assign text_out = text_out_r;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
module tb_aes_inv_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ld;
  logic [127:0] text_in;
  logic         kreq;
  logic [3:0]   kround;
  logic         kvalid;
  logic [31:0]  w0, w1, w2, w3;
  logic [127:0] sa_o;
  logic [127:0] inv_sb_in;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] text_out;

  int passed = 0;
  int total  = 0;

  logic [7:0]   sbox_t [256];
  logic [7:0]   inv_t  [256];
  logic [127:0] rk_tab [11];

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  aes_inv_round_ctrl #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .ld(ld), .text_in(text_in),
    .kreq(kreq), .kround(kround), .kvalid(kvalid),
    .w_0(w0), .w_1(w1), .w_2(w2), .w_3(w3),
    .sa_o(sa_o), .inv_sb_in(inv_sb_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .text_out(text_out)
  );

  always #5 clk = ~clk;

  // ---- reference AES pieces (external logic + key supplier) -------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int i = 1; i < 256; i++)
      if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = 4 * ((c - r + 4) % 4) + r;
        o[127-8*(4*c+r) -: 8] = inv_t[s[127-8*src -: 8]];
      end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  assign inv_sb_in = inv_sr_sb(sa_o);
  assign {w0, w1, w2, w3} = (kround <= 4'd10) ? rk_tab[kround] : 128'h0;

  // ---- checking ---------------------------------------------------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a decryption and runs until out_valid (bounded). kround order and
  // sa_o freeze during stalls are checked on the way.
  task automatic run(input logic [127:0] ct, input int stall_key, input int stall_r5,
                     input bit ld_noise, output int lat);
    int          exp_k = 10;
    logic [127:0] prev;
    bit          stalled;
    text_in = ct;
    ld      = 1'b1;
    step();
    ld  = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      stalled = 1'b0;
      if (kreq && kround == 4'd10 && stall_key > 0) begin
        stalled = 1'b1; stall_key--;
      end else if (kreq && kround == 4'd5 && stall_r5 > 0) begin
        stalled = 1'b1; stall_r5--;
      end
      kvalid = !stalled;
      if (ld_noise) begin
        ld      = 1'b1;
        text_in = {$urandom, $urandom, $urandom, $urandom};
      end
      if (kreq && kvalid) begin
        chk("kround_order", 128'(kround), 128'(exp_k));
        exp_k--;
      end
      prev = sa_o;
      step();
      lat++;
      if (stalled) chk("sa_frozen_in_stall", sa_o, prev);
    end
    ld     = 1'b0;
    kvalid = 1'b1;
    chk("run_reached_done", 128'(out_valid), 128'd1);
  endtask

  int lat;
  logic [127:0] held;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
    for (int i = 0; i < 256; i++) inv_t[sbox_t[i]] = 8'(i);
    expand_key(KEY_C1);

    rst_n = 1'b0; ld = 1'b0; text_in = '0; kvalid = 1'b1; out_ready = 1'b1;
    #12;
    chk("rst_sa_o",      sa_o,                 128'h0);
    chk("rst_text_out",  text_out,             128'h0);
    chk("rst_ctrl",      {kreq, busy, out_valid, kround}, 128'h0);
    rst_n = 1'b1;
    step();
    chk("idle_kround", 128'(kround), 128'h0);

    // FIPS-197 C.1, key always valid
    run(CT_C1, 0, 0, 1'b0, lat);
    chk("c1_latency",   128'(lat),  128'd12);
    chk("c1_plaintext", text_out,   PT_C1);
    chk("c1_sa_eq_out", sa_o,       PT_C1);
    chk("c1_busy",      128'(busy), 128'd1);
    step();
    chk("c1_accept_valid", 128'({out_valid, busy}), 128'd0);
`ifdef AES_INV_ZEROIZE_EN
    chk("c1_zeroize_text_out", text_out, 128'h0);
    chk("c1_zeroize_sa",       sa_o,     128'h0);
`else
    chk("c1_retain_text_out",  text_out, PT_C1);
`endif
    step();

    // key stalls: 3 cycles in KEY, 2 at round 5
    run(CT_C1, 3, 2, 1'b0, lat);
    chk("stall_latency",   128'(lat), 128'd17);
    chk("stall_plaintext", text_out,  PT_C1);
    step();

    // backpressure + ld pulses while busy
    out_ready = 1'b0;
    run(CT_C1, 0, 0, 1'b1, lat);
    chk("bp_latency",   128'(lat), 128'd12);
    chk("bp_plaintext", text_out,  PT_C1);
    held = text_out;
    for (int i = 0; i < 4; i++) begin
      ld      = 1'b1;
      text_in = {$urandom, $urandom, $urandom, $urandom};
      step();
      chk("bp_valid_held", 128'({out_valid, busy}), 128'd3);
      chk("bp_text_held",  text_out, held);
    end
    // acceptance with a simultaneous ld: ld must be dropped
    out_ready = 1'b1;
    ld        = 1'b1;
    step();
    ld = 1'b0;
    chk("bp_accept", 128'({out_valid, busy}), 128'd0);
    step();
    chk("bp_ld_at_accept_ignored", 128'({busy, kreq}), 128'd0);
    run(CT_C1, 0, 0, 1'b0, lat);
    chk("bp_next_plaintext", text_out, PT_C1);
    step();

    // reset in the middle of round 4
    text_in = CT_C1;
    ld      = 1'b1;
    step();
    ld = 1'b0;
    for (int i = 0; i < 20 && kround != 4'd4; i++) step();
    chk("midop_reached_r4", 128'(kround), 128'd4);
    rst_n = 1'b0;
    #1;
    chk("midop_rst_sa",   sa_o,     128'h0);
    chk("midop_rst_text", text_out, 128'h0);
    chk("midop_rst_ctrl", 128'({kreq, busy, out_valid, kround}), 128'h0);
    #2;
    rst_n = 1'b1;
    step();
    run(CT_C1, 0, 0, 1'b0, lat);
    chk("midop_after_plaintext", text_out,  PT_C1);
    chk("midop_after_latency",   128'(lat), 128'd12);
    step();

    // back-to-back: C.1 then FIPS-197 appendix B, ld right after acceptance
    run(CT_C1, 0, 0, 1'b0, lat);
    chk("b2b_first", text_out, PT_C1);
    step();
    expand_key(KEY_B);
    run(CT_B, 0, 0, 1'b0, lat);
    chk("b2b_second",         text_out,  PT_B);
    chk("b2b_second_latency", 128'(lat), 128'd12);
    step();
    chk("b2b_idle", 128'({out_valid, busy}), 128'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
